sccb_reg_slave: RTL and testbench

SCCB_REG_SLAVE -- requirements
Module: sccb_reg_slave

---
 rtl/sccb_reg_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_sccb_reg_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_slave.sv
// SCCB register slave: 16-bit register pointer, ACKed sequential writes, glitch-filtered bus inputs.
// Define SCCB_RD_EN to compile in the read path (RDATA/RACK states); reads are NACKed otherwise.
module sccb_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 4
) (
  input  logic        clk_100,
  input  logic        rst_100,
  input  logic        sclk,
  inout  wire         sda,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data
);
  localparam int CW = $clog2(FILT_LEN + 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV     = 4'd1;
  localparam logic [3:0] ACK_DEV = 4'd2;
  localparam logic [3:0] ADDR_H  = 4'd3;
  localparam logic [3:0] ACK_AH  = 4'd4;
  localparam logic [3:0] ADDR_L  = 4'd5;
  localparam logic [3:0] ACK_AL  = 4'd6;
  localparam logic [3:0] WDATA   = 4'd7;
  localparam logic [3:0] ACK_W   = 4'd8;
`ifdef SCCB_RD_EN
  localparam logic [3:0] RDATA   = 4'd9;
  localparam logic [3:0] RACK    = 4'd10;
`endif

  // index 1 = sclk, index 0 = sda
  logic [1:0]         s1_q, s1_d, s2_q, s2_d, flt_q, flt_d, prv_q, prv_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = {sclk, sda};
    s2_d  = s1_q;
    prv_d = flt_q;
    flt_d = flt_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      // a new level is accepted only after FILT_LEN consecutive differing samples
      if (s2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == CW'(FILT_LEN - 1)) flt_d[i] = s2_q[i];
        else                               cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  logic scl_rise, scl_fall, sda_f, start_c, stop_c;
  assign sda_f    = flt_q[0];
  assign scl_rise =  flt_q[1] & ~prv_q[1];
  assign scl_fall = ~flt_q[1] &  prv_q[1];
  assign start_c  = flt_q[1] & prv_q[1] & ~flt_q[0] &  prv_q[0];
  assign stop_c   = flt_q[1] & prv_q[1] &  flt_q[0] & ~prv_q[0];

  logic [3:0]  state_q, state_d, bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, addr_h_q, addr_h_d, wr_data_q, wr_data_d;
  logic [15:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic        oe_q, oe_d, wr_valid_q, wr_valid_d;
  logic        rx_st, byte_done, dev_ok;

  assign rx_st     = (state_q == DEV) || (state_q == ADDR_H) ||
                     (state_q == ADDR_L) || (state_q == WDATA);
  assign byte_done = rx_st && scl_fall && (bit_q == 4'd8);

`ifdef SCCB_RD_EN
  logic rw_q, rw_d, mack_q, mack_d;
  assign dev_ok = (shift_q[7:1] == DEV_ADDR);
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
  assign dev_ok    = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
`endif

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    addr_h_d   = addr_h_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef SCCB_RD_EN
    rw_d       = rw_q;
    mack_d     = mack_q;
`endif
    if (rx_st && scl_rise) begin
      shift_d = {shift_q[6:0], sda_f};
      bit_d   = bit_q + 4'd1;
    end
    // ACK is driven from the falling edge after bit 8 until the next falling edge
    if (byte_done) begin
      bit_d = 4'd0;
      oe_d  = 1'b1;
    end
    case (state_q)
      DEV: if (byte_done) begin
        if (dev_ok) state_d = ACK_DEV;
        else begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
`ifdef SCCB_RD_EN
        rw_d = shift_q[0];
`endif
      end
      ADDR_H: if (byte_done) begin
        addr_h_d = shift_q;
        state_d  = ACK_AH;
      end
      ADDR_L: if (byte_done) begin
        ptr_d   = {addr_h_q, shift_q};
        state_d = ACK_AL;
      end
      WDATA: if (byte_done) state_d = ACK_W;
      ACK_DEV: if (scl_fall) begin
        oe_d    = 1'b0;
        state_d = ADDR_H;
`ifdef SCCB_RD_EN
        if (rw_q) begin
          shift_d = rd_data;
          oe_d    = ~rd_data[7];
          bit_d   = 4'd0;
          state_d = RDATA;
        end
`endif
      end
      ACK_AH: if (scl_fall) begin
        oe_d    = 1'b0;
        state_d = ADDR_L;
      end
      ACK_AL: if (scl_fall) begin
        oe_d    = 1'b0;
        state_d = WDATA;
      end
      ACK_W: if (scl_fall) begin
        oe_d       = 1'b0;
        wr_valid_d = 1'b1;
        wr_addr_d  = ptr_q;
        wr_data_d  = shift_q;
        ptr_d      = ptr_q + 16'd1;
        state_d    = WDATA;
      end
`ifdef SCCB_RD_EN
      RDATA: if (scl_fall) begin
        if (bit_q == 4'd7) begin
          oe_d    = 1'b0;
          bit_d   = 4'd0;
          state_d = RACK;
        end else begin
          shift_d = {shift_q[6:0], 1'b0};
          oe_d    = ~shift_q[6];
          bit_d   = bit_q + 4'd1;
        end
      end
      // pointer advances at the ACK sample so rd_data settles before the next load
      RACK: begin
        if (scl_rise) begin
          mack_d = sda_f;
          ptr_d  = ptr_q + 16'd1;
        end
        if (scl_fall) begin
          if (!mack_q) begin
            shift_d = rd_data;
            oe_d    = ~rd_data[7];
            bit_d   = 4'd0;
            state_d = RDATA;
          end else state_d = IDLE;
        end
      end
`endif
      default: ;
    endcase
    if (start_c || stop_c) begin
      state_d = start_c ? DEV : IDLE;
      bit_d   = 4'd0;
      oe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      s1_q       <= 2'b11;
      s2_q       <= 2'b11;
      flt_q      <= 2'b11;
      prv_q      <= 2'b11;
      cnt_q      <= '0;
      state_q    <= IDLE;
      bit_q      <= 4'd0;
      shift_q    <= 8'd0;
      addr_h_q   <= 8'd0;
      ptr_q      <= 16'd0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
`ifdef SCCB_RD_EN
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
`endif
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      flt_q      <= flt_d;
      prv_q      <= prv_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      addr_h_q   <= addr_h_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef SCCB_RD_EN
      rw_q       <= rw_d;
      mack_q     <= mack_d;
`endif
    end
  end

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
endmodule

// File: tb/tb_sccb_reg_slave.sv
// Directed bench for sccb_reg_slave: a bit-banged SCCB master drives sclk/sda with a pull-up.
// Read scenario is exercised as ACKed read when SCCB_RD_EN is defined, as NACK otherwise.
module tb_sccb_reg_slave;
  localparam int Q = 16;  // quarter bus period in clk_100 cycles

  logic        clk_100 = 1'b0;
  logic        rst_100 = 1'b1;
  logic        sclk = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda_bus;
  logic        wr_valid;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = 8'h56;

  int   checks = 0, failures = 0;
  int   wv_cnt = 0, wv_long = 0;
  logic wv_prev = 1'b0;
  logic slave_drove = 1'b0;
  logic [15:0] wv_addr [8];
  logic [7:0]  wv_data [8];

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk_100 = ~clk_100;

  sccb_reg_slave #(.DEV_ADDR(7'h3C), .FILT_LEN(4)) dut (
    .clk_100 (clk_100),
    .rst_100 (rst_100),
    .sclk    (sclk),
    .sda     (sda_bus),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always @(negedge clk_100) begin
    if (wr_valid === 1'b1) begin
      if (wv_cnt < 8) begin
        wv_addr[wv_cnt] = wr_addr;
        wv_data[wv_cnt] = wr_data;
      end
      if (wv_prev) wv_long++;
      wv_cnt++;
    end
    wv_prev = (wr_valid === 1'b1);
    if (!m_sda_low && sda_bus === 1'b0) slave_drove = 1'b1;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wq(Q);
    sclk = 1'b1;      wq(Q);
    m_sda_low = 1'b1; wq(Q);
    sclk = 1'b0;      wq(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wq(Q);
    sclk = 1'b1;      wq(Q);
    m_sda_low = 1'b0; wq(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda_low = ~b; wq(Q);
    sclk = 1'b1;    wq(Q);
    if (glitch) begin
      sclk = 1'b0; wq(1);
      sclk = 1'b1; wq(Q - 1);
    end else wq(Q);
    sclk = 1'b0;    wq(Q);
  endtask

  task automatic ack_slot(output logic ack);
    m_sda_low = 1'b0; wq(Q);
    sclk = 1'b1;      wq(Q);
    ack = (sda_bus === 1'b0);
    wq(Q);
    sclk = 1'b0;      wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    ack_slot(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda_low = 1'b0; wq(Q);
      sclk = 1'b1;      wq(Q);
      d = {d[6:0], (sda_bus === 1'b0) ? 1'b0 : 1'b1};
      wq(Q);
      sclk = 1'b0;      wq(Q);
    end
    m_sda_low = mack; wq(Q);
    sclk = 1'b1;      wq(2 * Q);
    sclk = 1'b0;      wq(Q);
  endtask

  task automatic test_reset();
    rst_100 = 1'b1; wq(6);
    checks++; if (wr_valid !== 1'b0)     begin failures++; $display("FAIL rst_wr_valid got=%0b exp=0", wr_valid); end
    checks++; if (wr_addr !== 16'h0000)  begin failures++; $display("FAIL rst_wr_addr got=%h exp=0000", wr_addr); end
    checks++; if (wr_data !== 8'h00)     begin failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
    checks++; if (rd_addr !== 16'h0000)  begin failures++; $display("FAIL rst_rd_addr got=%h exp=0000", rd_addr); end
    checks++; if (sda_bus !== 1'b1)      begin failures++; $display("FAIL rst_sda got=%b exp=1", sda_bus); end
    rst_100 = 1'b0; wq(8);
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    logic       ack;
    bytes = '{8'h78, 8'h31, 8'h03, 8'h11};
    wv_cnt = 0; wv_long = 0;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack%0d got=%b exp=1", i, ack); end
    end
    bus_stop();
    checks++; if (wv_cnt !== 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", wv_cnt); end
    checks++; if (wv_addr[0] !== 16'h3103) begin failures++; $display("FAIL wr_addr got=%h exp=3103", wv_addr[0]); end
    checks++; if (wv_data[0] !== 8'h11) begin failures++; $display("FAIL wr_data got=%h exp=11", wv_data[0]); end
    checks++; if (rd_addr !== 16'h3104) begin failures++; $display("FAIL wr_rd_addr got=%h exp=3104", rd_addr); end
    checks++; if (wv_long !== 0) begin failures++; $display("FAIL wr_pulse_width got=%0d exp=0", wv_long); end
  endtask

  task automatic test_nack();
    logic [7:0] bytes [4];
    logic       ack;
    bytes = '{8'h7A, 8'h31, 8'h03, 8'h11};
    wv_cnt = 0; slave_drove = 1'b0;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL nack_slot%0d got=%b exp=0", i, ack); end
    end
    bus_stop();
    checks++; if (slave_drove !== 1'b0) begin failures++; $display("FAIL nack_sda_driven got=%b exp=0", slave_drove); end
    checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL nack_wr_count got=%0d exp=0", wv_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic       ack;
    bytes = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB};
    wv_cnt = 0; wv_long = 0;
    bus_start();
    for (int i = 0; i < 5; i++) send_byte(bytes[i], ack);
    bus_stop();
    checks++; if (wv_cnt !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", wv_cnt); end
    checks++; if (wv_addr[0] !== 16'hFFFF || wv_data[0] !== 8'hAA)
      begin failures++; $display("FAIL b2b_first got=%h/%h exp=ffff/aa", wv_addr[0], wv_data[0]); end
    checks++; if (wv_addr[1] !== 16'h0000 || wv_data[1] !== 8'hBB)
      begin failures++; $display("FAIL b2b_wrap got=%h/%h exp=0000/bb", wv_addr[1], wv_data[1]); end
    checks++; if (rd_addr !== 16'h0001) begin failures++; $display("FAIL b2b_rd_addr got=%h exp=0001", rd_addr); end
    checks++; if (wv_long !== 0) begin failures++; $display("FAIL b2b_pulse_width got=%0d exp=0", wv_long); end
  endtask

  task automatic test_stop_abort();
    logic [7:0] d;
    logic       ack;
    wv_cnt = 0;
    d = 8'h42;
    bus_start();
    send_byte(8'h78, ack);
    send_byte(8'h00, ack);
    send_byte(8'h10, ack);
    for (int i = 7; i >= 3; i--) send_bit(d[i], 1'b0);
    bus_stop();
    checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL abort_count got=%0d exp=0", wv_cnt); end
    checks++; if (rd_addr !== 16'h0010) begin failures++; $display("FAIL abort_rd_addr got=%h exp=0010", rd_addr); end
    bus_start();
    send_byte(8'h78, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL abort_next_ack got=%b exp=1", ack); end
    send_byte(8'h00, ack);
    send_byte(8'h20, ack);
    send_byte(8'h55, ack);
    bus_stop();
    checks++; if (wv_cnt !== 1 || wv_addr[0] !== 16'h0020 || wv_data[0] !== 8'h55)
      begin failures++; $display("FAIL abort_next_wr got=%0d:%h/%h exp=1:0020/55", wv_cnt, wv_addr[0], wv_data[0]); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    wv_cnt = 0;
    bus_start();
    send_byte(8'h78, ack);
    send_byte(8'h30, ack);
    send_byte(8'h0A, ack);
    bus_start();
    send_byte(8'h79, ack);
`ifdef SCCB_RD_EN
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_dev_ack got=%b exp=1", ack); end
    recv_byte(1'b0, d);
    bus_stop();
    checks++; if (d !== 8'h56) begin failures++; $display("FAIL rd_data got=%h exp=56", d); end
    checks++; if (rd_addr !== 16'h300B) begin failures++; $display("FAIL rd_ptr got=%h exp=300b", rd_addr); end
`else
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_dev_nack got=%b exp=0", ack); end
    d = 8'h00;
    bus_stop();
    checks++; if (rd_addr !== 16'h300A) begin failures++; $display("FAIL rd_ptr got=%h exp=300a", rd_addr); end
`endif
    checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL rd_wr_count got=%0d exp=0", wv_cnt); end
  endtask

  task automatic test_glitch_reset();
    logic       ack;
    logic [7:0] h, l;
    h = 8'h12; l = 8'h34;
    wv_cnt = 0;
    bus_start();
    send_byte(8'h78, ack);
    for (int i = 7; i >= 0; i--) send_bit(h[i], i == 4);
    ack_slot(ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL glitch_ah_ack got=%b exp=1", ack); end
    for (int i = 7; i >= 4; i--) send_bit(l[i], 1'b0);
    m_sda_low = 1'b0;
    rst_100 = 1'b1; wq(1);
    rst_100 = 1'b0; wq(2);
    slave_drove = 1'b0;
    checks++; if (sda_bus !== 1'b1)     begin failures++; $display("FAIL grst_sda got=%b exp=1", sda_bus); end
    checks++; if (wr_valid !== 1'b0)    begin failures++; $display("FAIL grst_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_addr !== 16'h0000) begin failures++; $display("FAIL grst_wr_addr got=%h exp=0000", wr_addr); end
    checks++; if (wr_data !== 8'h00)    begin failures++; $display("FAIL grst_wr_data got=%h exp=00", wr_data); end
    checks++; if (rd_addr !== 16'h0000) begin failures++; $display("FAIL grst_rd_addr got=%h exp=0000", rd_addr); end
    for (int i = 3; i >= 0; i--) send_bit(l[i], 1'b0);
    ack_slot(ack);
    send_byte(8'h99, ack);
    bus_stop();
    checks++; if (slave_drove !== 1'b0) begin failures++; $display("FAIL grst_sda_driven got=%b exp=0", slave_drove); end
    checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL grst_wr_count got=%0d exp=0", wv_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_back_to_back();
    test_stop_abort();
    test_read();
    test_glitch_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
